// File: rtl/snake_dir_ctrl.sv
// Synchronizes PS/2 key-release events into clk and turns them into direction, pause and restart, with a 2-deep turn queue.
// Latency detect->outputs SYNC_STAGES+2 cycles; no backpressure: turns arriving with a full queue are dropped.
module snake_dir_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] INIT_DIR    = 2'b11
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] keycode,
  input  logic       detect,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       paused,
  output logic       restart,
  output logic       key_valid,
  output logic [1:0] q_count
);

  localparam logic [7:0] KC_W     = 8'h1D;
  localparam logic [7:0] KC_A     = 8'h1C;
  localparam logic [7:0] KC_S     = 8'h1B;
  localparam logic [7:0] KC_D     = 8'h23;
  localparam logic [7:0] KC_SPACE = 8'h29;
  localparam logic [7:0] KC_R     = 8'h2D;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   det_s;
  logic                   det_prev;
  logic                   ev;
  logic                   ev_r;
  logic [7:0]             kc_r;

  logic [1:0] q0, q1;
  logic [1:0] q0_n, q1_n, cnt_n, dir_n;
  logic       paused_n, restart_n, key_valid_n;

  logic       is_dir_key;
  logic [1:0] req;
  logic [1:0] ref_dir;
  logic       push, pop;

  assign det_s = sync_q[SYNC_STAGES-1];
  assign ev    = det_s & ~det_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= '0;
      det_prev <= 1'b0;
      ev_r     <= 1'b0;
      kc_r     <= 8'h00;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], detect};
      det_prev <= det_s;
      ev_r     <= ev;
      if (ev) kc_r <= keycode;
    end
  end

  always_comb begin
    is_dir_key = 1'b1;
    req        = DIR_UP;
    case (kc_r)
      KC_W:    req = DIR_UP;
      KC_A:    req = DIR_LEFT;
      KC_S:    req = DIR_DOWN;
      KC_D:    req = DIR_RIGHT;
      default: is_dir_key = 1'b0;
    endcase
  end

  // New turns are checked against the newest queued entry, not the live direction.
  always_comb begin
    ref_dir = dir;
    if (q_count == 2'd2)      ref_dir = q1;
    else if (q_count == 2'd1) ref_dir = q0;
  end

  assign push = ev_r & is_dir_key & (req != ref_dir) &
                (req != (ref_dir ^ 2'b10)) & (q_count != 2'd2);
  assign pop  = tick & ~paused & (q_count != 2'd0);

  always_comb begin
    dir_n       = dir;
    paused_n    = paused;
    q0_n        = q0;
    q1_n        = q1;
    cnt_n       = q_count;
    key_valid_n = ev_r;
    restart_n   = ev_r & (kc_r == KC_R);

    if (restart_n) begin
      dir_n    = INIT_DIR;
      paused_n = 1'b0;
      cnt_n    = 2'd0;
    end else begin
      if (ev_r && kc_r == KC_SPACE) paused_n = ~paused;
      if (pop) dir_n = q0;
      // push and pop together is only possible with exactly one entry queued
      if (push && pop) begin
        q0_n = req;
      end else if (push) begin
        if (q_count == 2'd0) q0_n = req;
        else                 q1_n = req;
        cnt_n = q_count + 2'd1;
      end else if (pop) begin
        q0_n  = q1;
        cnt_n = q_count - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dir       <= INIT_DIR;
      paused    <= 1'b0;
      restart   <= 1'b0;
      key_valid <= 1'b0;
      q_count   <= 2'd0;
      q0        <= 2'b00;
      q1        <= 2'b00;
    end else begin
      dir       <= dir_n;
      paused    <= paused_n;
      restart   <= restart_n;
      key_valid <= key_valid_n;
      q_count   <= cnt_n;
      q0        <= q0_n;
      q1        <= q1_n;
    end
  end

endmodule
